key_scheduler: RTL and testbench
================================

KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameters SHALL be: N, 8, data byte width; KEY_MAX, 16, maximum key length in letters.
REQ-002 Ports SHALL be:
- clock  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- key_clr  in  1  clear key, enter LOAD.
- key_wr  in  1  write key_char into key store.
- key_char  in  8  ASCII key letter.
- key_done  in  1  end key load.
- mode  in  2  direction code, sampled at key_done.
- din_valid  in  1  input byte valid.
- din  in  N  input byte.
- din_ready  out  1  byte accepted when din_valid && din_ready.
- en  out  1  output byte valid to encryption stage.
- dout  out  N  byte to encryption stage.
- shift  out  5  per-byte shift, 0..25.
- direction  out  2  mode forwarded unchanged.
- key_err  out  1  sticky key error flag.
- run  out  1  high in RUN state.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, RUN; reset state IDLE.
REQ-004 IDLE->LOAD on key_clr; LOAD->RUN on key_done with key length >0; LOAD stays LOAD on key_done with length 0 and sets key_err.
REQ-005 key_clr in any state SHALL go to LOAD, clear length and index to 0, and clear key_err; key_clr beats key_wr, key_done, and din handshake in the same cycle.
REQ-006 In LOAD, key_wr with key_char in 'A'..'Z' or 'a'..'z' SHALL store (key_char - 'A') or (key_char - 'a') at slot [length] and increment length.
REQ-007 In LOAD, key_wr with a non-letter, or with length == KEY_MAX, SHALL leave the store unchanged and set key_err.
REQ-008 key_wr and key_done together SHALL store the character first, then evaluate length for the transition.
REQ-009 mode SHALL be captured into direction on the cycle LOAD->RUN; direction holds until the next capture.
REQ-010 din_ready SHALL be combinational: (state == RUN) && !key_clr.
REQ-011 On an accepted byte, the next cycle SHALL show en=1, dout=din, and direction as held.
- If din is a letter: shift=key[index], and index then increments, wrapping to 0 when index == length-1.
- If din is not a letter: shift=0 and index is unchanged.
REQ-012 With no accepted byte, en SHALL be 0 next cycle; dout and shift hold last values.
REQ-013 Latency SHALL be exactly 1 cycle input->output, with throughput 1 byte/cycle in RUN.
REQ-014 run SHALL equal (state == RUN), registered from state.

Reset
REQ-015 While rst=0, outputs SHALL be: en=0, dout=0, shift=0, direction=0, key_err=0, run=0, din_ready=0; also state=IDLE, length=0, index=0.
REQ-016 Reset asserted mid-stream SHALL drop any in-flight byte, with no en pulse after release.
REQ-017 The key store contents SHALL need no reset; it is read only at index < length.

Structure
REQ-018 Package cipher_pkg SHALL hold: state enum, SHIFT_W=5, ALPHA=26, KEY_MAX default, and a letter-classify/offset function shared with the encryption stage.
REQ-019 One sub-module, key_store (KEY_MAX x 5-bit register file, one write port, one read port), SHALL be used.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, clr, key "KEY", done, mode=2'b10, din "AAAA" -> shift 10,4,24,10; direction=2'b10; en 1 cycle after each accept.
- Key "ab", din "a b" (0x61,0x20,0x62) -> shift 0,0,1; index not advanced on space.
- 17 key_wr letters -> length=16, key_err=1; key_done -> RUN.
- key_done with no letters -> stays LOAD, key_err=1, din_ready=0.
- key_clr with din_valid=1 in RUN -> byte not accepted, en=0 next cycle, state LOAD.
- rst low while streaming -> en=0 and all outputs 0; after release, state IDLE and din_ready=0.

Source files
------------

// File: rtl/cipher_pkg.sv
// cipher_pkg: shared types and letter classification for the key scheduler and encryption stage.
// Rev 1.0
`default_nettype none

package cipher_pkg;

    localparam int SHIFT_W         = 5;
    localparam int ALPHA           = 26;
    localparam int KEY_MAX_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic               is_letter;
        logic [SHIFT_W-1:0] offset;
    } letter_t;

    // Case-insensitive alphabet position; offset is 0 for non-letters.
    function automatic letter_t classify_letter(input logic [7:0] c);
        letter_t    r;
        logic [7:0] d;
        r = '0;
        d = 8'h00;
        if (c >= 8'h41 && c <= 8'h5A) begin
            r.is_letter = 1'b1;
            d           = c - 8'h41;
        end else if (c >= 8'h61 && c <= 8'h7A) begin
            r.is_letter = 1'b1;
            d           = c - 8'h61;
        end
        r.offset = d[SHIFT_W-1:0];
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_store.sv
// key_store: key letter register file, one write port and one asynchronous read port.
// Rev 1.0
`default_nettype none

module key_store
    import cipher_pkg::*;
#(
    parameter int DEPTH = KEY_MAX_DEFAULT,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [SHIFT_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [SHIFT_W-1:0] rdata_o
);

    // Contents are only read below the current key length, so no reset is needed.
    logic [SHIFT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/key_scheduler.sv
// key_scheduler: loads a Vigenere key and tags each streamed byte with its per-letter shift.
// Rev 1.0
`default_nettype none

module key_scheduler
    import cipher_pkg::*;
#(
    parameter int N       = 8,
    parameter int KEY_MAX = KEY_MAX_DEFAULT
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               key_clr,
    input  logic               key_wr,
    input  logic [7:0]         key_char,
    input  logic               key_done,
    input  logic [1:0]         mode,
    input  logic               din_valid,
    input  logic [N-1:0]       din,
    output logic               din_ready,
    output logic               en,
    output logic [N-1:0]       dout,
    output logic [SHIFT_W-1:0] shift,
    output logic [1:0]         direction,
    output logic               key_err,
    output logic               run
);

    localparam int AW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
    localparam int LW = $clog2(KEY_MAX + 1);

    state_t             state_q;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      len_d;
    logic [AW-1:0]      idx_q;
    logic               key_err_q;
    logic [1:0]         direction_q;
    logic               en_q;
    logic [N-1:0]       dout_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               run_q;

    letter_t            key_cls;
    letter_t            din_cls;
    logic               wr_attempt;
    logic               wr_ok;
    logic               accept;
    logic               idx_last;
    logic [AW-1:0]      wr_addr;
    logic [SHIFT_W-1:0] ks_rdata;

    assign key_cls    = classify_letter(key_char);
    assign din_cls    = classify_letter(8'(din));
    assign wr_attempt = (state_q == ST_LOAD) && key_wr && !key_clr;
    assign wr_ok      = wr_attempt && key_cls.is_letter && (len_q < LW'(KEY_MAX));
    // Length including a write landing this cycle, so key_wr+key_done can complete a key.
    assign len_d      = len_q + LW'(wr_ok);
    assign wr_addr    = AW'(len_q);
    assign din_ready  = (state_q == ST_RUN) && !key_clr;
    assign accept     = din_valid && din_ready;
    assign idx_last   = (LW'(idx_q) == (len_q - LW'(1)));

    key_store #(
        .DEPTH (KEY_MAX),
        .AW    (AW)
    ) u_key_store (
        .clk_i   (clock),
        .we_i    (wr_ok),
        .waddr_i (wr_addr),
        .wdata_i (key_cls.offset),
        .raddr_i (idx_q),
        .rdata_o (ks_rdata)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            key_err_q   <= 1'b0;
            direction_q <= 2'b00;
            en_q        <= 1'b0;
            dout_q      <= '0;
            shift_q     <= '0;
            run_q       <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if (key_clr) begin
                state_q   <= ST_LOAD;
                len_q     <= '0;
                idx_q     <= '0;
                key_err_q <= 1'b0;
                run_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        run_q <= 1'b0;
                    end
                    ST_LOAD: begin
                        len_q <= len_d;
                        if (wr_attempt && !wr_ok) begin
                            key_err_q <= 1'b1;
                        end
                        if (key_done) begin
                            if (len_d != '0) begin
                                state_q     <= ST_RUN;
                                run_q       <= 1'b1;
                                direction_q <= mode;
                            end else begin
                                key_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (accept) begin
                            en_q   <= 1'b1;
                            dout_q <= din;
                            if (din_cls.is_letter) begin
                                shift_q <= ks_rdata;
                                idx_q   <= idx_last ? '0 : idx_q + AW'(1);
                            end else begin
                                shift_q <= '0;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        run_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign en        = en_q;
    assign dout      = dout_q;
    assign shift     = shift_q;
    assign direction = direction_q;
    assign key_err   = key_err_q;
    assign run       = run_q;

endmodule

`default_nettype wire

// File: tb/tb_key_scheduler.sv
// tb_key_scheduler: directed scenarios plus randomized traffic against a queue-based key model.
// Rev 1.0
`default_nettype none

module tb_key_scheduler;

    localparam int N       = 8;
    localparam int KEY_MAX = 16;
    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_RUN   = 2;

    logic         clock = 1'b0;
    logic         rst;
    logic         key_clr;
    logic         key_wr;
    logic [7:0]   key_char;
    logic         key_done;
    logic [1:0]   mode;
    logic         din_valid;
    logic [N-1:0] din;
    logic         din_ready;
    logic         en;
    logic [N-1:0] dout;
    logic [4:0]   shift;
    logic [1:0]   direction;
    logic         key_err;
    logic         run;

    always #5 clock = ~clock;

    key_scheduler #(
        .N       (N),
        .KEY_MAX (KEY_MAX)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .key_clr   (key_clr),
        .key_wr    (key_wr),
        .key_char  (key_char),
        .key_done  (key_done),
        .mode      (mode),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .en        (en),
        .dout      (dout),
        .shift     (shift),
        .direction (direction),
        .key_err   (key_err),
        .run       (run)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: key kept as a queue of alphabet positions.
    int m_state;
    int m_key[$];
    int m_idx;
    int m_err;
    int m_dir;
    int m_en;
    int m_dout;
    int m_shift;

    function automatic bit is_alpha(input int c);
        return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
    endfunction

    function automatic int alpha_off(input int c);
        return (c >= 97) ? c - 97 : c - 65;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_key.delete();
        m_idx   = 0;
        m_err   = 0;
        m_dir   = 0;
        m_en    = 0;
        m_dout  = 0;
        m_shift = 0;
    endtask

    task automatic model_tick();
        m_en = 0;
        if (key_clr) begin
            m_state = S_LOAD;
            m_key.delete();
            m_idx = 0;
            m_err = 0;
        end else if (m_state == S_LOAD) begin
            if (key_wr) begin
                if (is_alpha(int'(key_char)) && m_key.size() < KEY_MAX)
                    m_key.push_back(alpha_off(int'(key_char)));
                else
                    m_err = 1;
            end
            if (key_done) begin
                if (m_key.size() > 0) begin
                    m_state = S_RUN;
                    m_dir   = int'(mode);
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_state == S_RUN && din_valid) begin
            m_en   = 1;
            m_dout = int'(din);
            if (is_alpha(int'(din))) begin
                m_shift = m_key[m_idx];
                m_idx   = (m_idx + 1) % m_key.size();
            end else begin
                m_shift = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("en",        32'(en),        32'(m_en));
        check("dout",      32'(dout),      32'(m_dout));
        check("shift",     32'(shift),     32'(m_shift));
        check("direction", 32'(direction), 32'(m_dir));
        check("key_err",   32'(key_err),   32'(m_err));
        check("run",       32'(run),       32'(m_state == S_RUN));
    endtask

    // Inputs are set just after an edge; step checks din_ready, clocks, then checks outputs.
    task automatic step();
        #1;
        check("din_ready", 32'(din_ready), 32'(rst && m_state == S_RUN && !key_clr));
        @(posedge clock);
        if (!rst) model_reset();
        else      model_tick();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        key_clr   = 1'b0;
        key_wr    = 1'b0;
        key_char  = 8'h00;
        key_done  = 1'b0;
        mode      = 2'b00;
        din_valid = 1'b0;
        din       = '0;
    endtask

    task automatic do_clr();
        key_clr = 1'b1; step(); key_clr = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] c);
        key_wr = 1'b1; key_char = c; step(); key_wr = 1'b0;
    endtask

    task automatic do_done(input logic [1:0] m);
        key_done = 1'b1; mode = m; step(); key_done = 1'b0; mode = ~m;
    endtask

    task automatic do_byte(input logic [7:0] b);
        din_valid = 1'b1; din = b; step(); din_valid = 1'b0;
    endtask

    task automatic do_key(input string s);
        for (int i = 0; i < s.len(); i++) do_wr(s[i]);
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] edges[4];
        edges = '{8'h40, 8'h5B, 8'h60, 8'h7B};
        case ($urandom_range(0, 3))
            0:       return 8'(65 + $urandom_range(0, 25));
            1:       return 8'(97 + $urandom_range(0, 25));
            2:       return 8'($urandom_range(0, 255));
            default: return edges[$urandom_range(0, 3)];
        endcase
    endfunction

    initial begin
        int s1[4];
        int s2[3];
        logic [7:0] s2_in[3];
        s1    = '{10, 4, 24, 10};
        s2    = '{0, 0, 1};
        s2_in = '{8'h61, 8'h20, 8'h62};

        rst = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clock);
        #1;
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check_outputs();
        rst = 1'b1;

        // Key "KEY", mode 10, stream "AAAA".
        do_clr();
        do_key("KEY");
        do_done(2'b10);
        for (int i = 0; i < 4; i++) begin
            do_byte(8'h41);
            check("s1_en", 32'(en), 32'd1);
            check("s1_shift", 32'(shift), 32'(s1[i]));
            check("s1_dir", 32'(direction), 32'd2);
        end
        step();
        check("s1_en_idle", 32'(en), 32'd0);

        // Key "ab", stream "a b": space does not advance the index.
        do_clr();
        do_key("ab");
        do_done(2'b01);
        for (int i = 0; i < 3; i++) begin
            do_byte(s2_in[i]);
            check("s2_shift", 32'(shift), 32'(s2[i]));
        end

        // 17 letters: 17th rejected, key wraps after 16.
        do_clr();
        do_key("ABCDEFGHIJKLMNOPQ");
        check("s3_err", 32'(key_err), 32'd1);
        do_done(2'b11);
        check("s3_run", 32'(run), 32'd1);
        for (int i = 0; i < 17; i++) do_byte(8'h41);
        check("s3_wrap", 32'(shift), 32'd0);

        // key_done with empty key.
        do_clr();
        do_done(2'b01);
        check("s4_err", 32'(key_err), 32'd1);
        check("s4_run", 32'(run), 32'd0);
        #1;
        check("s4_ready", 32'(din_ready), 32'd0);

        // key_clr beats a pending byte in RUN.
        do_key("Z");
        do_done(2'b00);
        key_clr = 1'b1; din_valid = 1'b1; din = 8'h41;
        step();
        key_clr = 1'b0; din_valid = 1'b0;
        check("s5_en", 32'(en), 32'd0);
        check("s5_run", 32'(run), 32'd0);

        // Reset while streaming.
        do_key("KEY");
        do_done(2'b10);
        din_valid = 1'b1; din = 8'h42;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("s6_en", 32'(en), 32'd0);
        check("s6_dout", 32'(dout), 32'd0);
        check("s6_shift", 32'(shift), 32'd0);
        check("s6_dir", 32'(direction), 32'd0);
        check("s6_ready", 32'(din_ready), 32'd0);
        model_reset();
        @(posedge clock);
        #1;
        step();
        rst = 1'b1;
        step();
        check("s6_post_en", 32'(en), 32'd0);
        check("s6_post_run", 32'(run), 32'd0);
        din_valid = 1'b0;

        // Randomized traffic.
        do_clr();
        for (int i = 0; i < 600; i++) begin
            key_clr   = ($urandom_range(0, 49) == 0);
            key_wr    = ($urandom_range(0, 2) == 0);
            key_char  = rand_char();
            key_done  = ($urandom_range(0, 9) == 0);
            mode      = 2'($urandom_range(0, 3));
            din_valid = ($urandom_range(0, 1) == 0);
            din       = rand_char();
            step();
        end
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
